store_ctrl: RTL

STORE_CTRL -- requirements
Module: store_ctrl

---
 rtl/store_pkg.sv | 28 ++
 rtl/store_lane_align.sv | 27 ++
 rtl/store_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/store_pkg.sv
// Shared constants for the store controller: funct3 store codes, FSM state
// encoding, lane masks and the latched lane-alignment record.
package store_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WR_LO = 2'd1;
    localparam logic [1:0] ST_WR_HI = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [3:0] MASK_SB = 4'b0001;
    localparam logic [3:0] MASK_SH = 4'b0011;
    localparam logic [3:0] MASK_SW = 4'b1111;

    // Byte enables and data spread across two adjacent words.
    typedef struct packed {
        logic [7:0]  be8;
        logic [63:0] d64;
    } lane_t;

    function automatic logic f3_valid(input logic [2:0] f3);
        return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane alignment: shifts the store mask and right-aligned data
// by the byte offset into a two-word (8-lane) window.
module store_lane_align
    import store_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [7:0]  be8,
    output logic [63:0] d64
);

    logic [3:0] mask;

    always_comb begin
        case (funct3)
            F3_SB:   mask = MASK_SB;
            F3_SH:   mask = MASK_SH;
            F3_SW:   mask = MASK_SW;
            default: mask = 4'b0000;
        endcase
    end

    assign be8 = {4'h0, mask} << off;
    assign d64 = {32'h0, data} << {off, 3'b000};

endmodule

// File: rtl/store_ctrl.sv
// Store controller: turns SB/SH/SW requests into word-aligned memory beats with
// a per-beat ack timeout. Define STORE_SPLIT_EN to issue misaligned stores as two beats.
module store_ctrl
    import store_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    output logic              done,
    output logic              fault
);

`ifdef STORE_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    localparam logic [7:0]        TMO_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [ADDR_W-3:0] WORD_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

    logic [1:0]        state_reg;
    logic [ADDR_W-3:0] waddr_reg;
    lane_t             lane_reg;
    logic              fault_reg;
    logic [7:0]        cnt_reg;

    logic [7:0]        be8_in;
    logic [63:0]       d64_in;
    logic              reject;
    logic [ADDR_W-3:0] waddr_inc;

    store_lane_align u_align (
        .funct3 (req_funct3),
        .off    (req_addr[1:0]),
        .data   (req_data),
        .be8    (be8_in),
        .d64    (d64_in)
    );

    // A store touching the upper word is only legal when splitting is built in.
    assign reject    = !f3_valid(req_funct3) || ((|be8_in[7:4]) && !SPLIT_EN);
    assign waddr_inc = waddr_reg + WORD_ONE;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        case (state_reg)
            ST_WR_LO: begin
                mem_we    = 1'b1;
                mem_addr  = {waddr_reg, 2'b00};
                mem_be    = lane_reg.be8[3:0];
                mem_wdata = lane_reg.d64[31:0];
            end
            ST_WR_HI: begin
                mem_we    = 1'b1;
                mem_addr  = {waddr_inc, 2'b00};
                mem_be    = lane_reg.be8[7:4];
                mem_wdata = lane_reg.d64[63:32];
            end
            default: ;
        endcase
    end

    assign req_ready = (state_reg == ST_IDLE);
    assign done      = (state_reg == ST_RESP);
    assign fault     = done && fault_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            waddr_reg <= '0;
            lane_reg  <= '0;
            fault_reg <= 1'b0;
            cnt_reg   <= 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        waddr_reg <= req_addr[ADDR_W-1:2];
                        lane_reg  <= {be8_in, d64_in};
                        cnt_reg   <= 8'd0;
                        fault_reg <= reject;
                        state_reg <= reject ? ST_RESP : ST_WR_LO;
                    end
                end
                ST_WR_LO: begin
                    if (mem_ack) begin
                        cnt_reg   <= 8'd0;
                        state_reg <= ((|lane_reg.be8[7:4]) && SPLIT_EN) ? ST_WR_HI : ST_RESP;
                    end else if (cnt_reg == TMO_LAST) begin
                        fault_reg <= 1'b1;
                        state_reg <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                ST_WR_HI: begin
                    if (mem_ack) begin
                        cnt_reg   <= 8'd0;
                        state_reg <= ST_RESP;
                    end else if (cnt_reg == TMO_LAST) begin
                        fault_reg <= 1'b1;
                        state_reg <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: begin
                    cnt_reg   <= 8'd0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
